// File: rtl/hack_mux_pkg.sv
// Shared constants and helpers for the registered Hack mux/arbiter.
package hack_mux_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   function automatic int unsigned wrap_inc(
      input int unsigned idx,
      input int unsigned ways
   );
      return (idx >= ways - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/hack_mux_arb_if.sv
// Producer-side and consumer-side channels of hack_mux_arb.
interface hack_mux_arb_if #(
   parameter int WIDTH = 16,
   parameter int WAYS  = 8,
   parameter int SEL_W = $clog2(WAYS)
);
   logic [WAYS*WIDTH-1:0] in_data;
   logic [WAYS-1:0]       in_valid;
   logic [WAYS-1:0]       in_ready;
   logic                  mode;
   logic [SEL_W-1:0]      sel;
   logic [WIDTH-1:0]      out_data;
   logic [SEL_W-1:0]      out_chan;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_chan, out_valid
   );

   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_chan, out_valid
   );
endinterface

// File: rtl/hack_rr_arbiter.sv
// Rotating-priority pick: first requester at or above ptr, wrapping.
module hack_rr_arbiter #(
   parameter int WAYS  = 8,
   parameter int SEL_W = $clog2(WAYS)
) (
   input  logic [WAYS-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] grant,
   output logic             grant_valid
);
   int j;

   // Scan from farthest to nearest so the nearest requester wins last.
   always_comb begin
      grant       = '0;
      grant_valid = |req;
      j           = 0;
      for (int k = WAYS - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= WAYS) j = j - WAYS;
         if (req[j]) grant = SEL_W'(j);
      end
   end
endmodule

// File: rtl/hack_mux_arb.sv
// Registered WAYS-to-1 mux with fixed-select or round-robin arbitration.
module hack_mux_arb
   import hack_mux_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int WAYS  = 8,
   parameter int SEL_W = $clog2(WAYS)
) (
   input logic             clk,
   input logic             reset,
   hack_mux_arb_if.slave   bus
);
   localparam logic [SEL_W:0] WAYS_L = WAYS[SEL_W:0];

   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] rr_grant;
   logic             rr_valid;
   logic [SEL_W-1:0] grant;
   logic             grant_valid;
   logic             sel_ok;
   logic             load_en;
   logic             xfer;

   hack_rr_arbiter #(
      .WAYS  (WAYS),
      .SEL_W (SEL_W)
   ) u_rr (
      .req         (bus.in_valid),
      .ptr         (ptr),
      .grant       (rr_grant),
      .grant_valid (rr_valid)
   );

   assign sel_ok  = {1'b0, bus.sel} < WAYS_L;
   assign load_en = !bus.out_valid || bus.out_ready;
   assign xfer    = load_en && grant_valid;

   always_comb begin
      grant       = bus.sel;
      grant_valid = sel_ok && bus.in_valid[bus.sel];
      if (bus.mode == MODE_RR) begin
         grant       = rr_grant;
         grant_valid = rr_valid;
      end
   end

   always_comb begin
      bus.in_ready = '0;
      if (xfer && !reset) bus.in_ready[grant] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_chan  <= '0;
         ptr           <= '0;
      end else if (xfer) begin
         bus.out_valid <= 1'b1;
         bus.out_data  <= bus.in_data[int'(grant)*WIDTH +: WIDTH];
         bus.out_chan  <= grant;
         if (bus.mode == MODE_RR)
            ptr <= SEL_W'(wrap_inc(32'(grant), WAYS));
      end else if (bus.out_ready) begin
         // Consumer took the word and nothing replaces it.
         bus.out_valid <= 1'b0;
      end
   end
endmodule

// File: doc/hack_mux_arb.md
Name: hack_mux_arb

Overview:
- Parametrised, registered successor to the Hack 8-way 16-bit multiplexer.
- Selects one of WAYS input channels, each WIDTH bits with a valid/ready handshake, and drives a single registered output channel.
- Two selection modes: fixed (external `sel`, as the combinational mux does) and round-robin (fair arbitration across valid inputs).
- Sits between multiple Hack data producers (for example, RAM banks or I/O sources) and one consumer.

Parameters:
- WIDTH, 16, data width per channel.
- WAYS, 8, number of input channels (≥2; need not be a power of two).
- SEL_W, $clog2(WAYS), width of `sel` and `out_chan`.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  WAYS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  WAYS  per-channel valid.
- in_ready  out  WAYS  per-channel ready (combinational).
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SEL_W  channel index used in fixed mode.
- out_data  out  WIDTH  registered output data.
- out_chan  out  SEL_W  index of the channel that sourced out_data.
- out_valid  out  1  registered output valid.
- out_ready  in  1  consumer ready.

Behaviour:
- Reset (synchronous, on a clk edge with reset=1):
  - out_valid=0, out_data=0, out_chan=0, round-robin pointer ptr=0.
  - in_ready is all-zero while reset is high.
  - Reset mid-transfer discards the held word.
- Load enable: load_en = !out_valid || out_ready. This gives a one-stage pipeline with full throughput of one word per cycle.
- Grant, combinational:
  - Fixed mode: grant=sel, grant_valid = in_valid[sel] && (sel < WAYS). If sel ≥ WAYS there is never a grant.
  - Round-robin mode: grant is the first i with in_valid[i], searching from ptr upward and wrapping WAYS-1→0. grant_valid = |in_valid.
- in_ready[i] = load_en && grant_valid && (i==grant) && !reset. At most one bit is set.
- Transfer on a clk edge when load_en && grant_valid:
  - out_data ← channel grant.
  - out_chan ← grant.
  - out_valid ← 1.
- Drain: if out_valid && out_ready && !grant_valid, then out_valid ← 0. out_data and out_chan hold their last value.
- Stall: while out_valid && !out_ready, out_data, out_chan and out_valid hold. No in_ready is asserted.
- Pointer:
  - Updates only on a transfer in round-robin mode: ptr ← (grant==WAYS-1) ? 0 : grant+1.
  - Fixed-mode transfers leave ptr unchanged.
- Latency: input handshake at edge N → word visible on out_data after edge N.
- Mode or sel changes take effect combinationally on the next grant. A word already registered is unaffected.
- Simultaneous drain and load in the same cycle: the new word replaces the old one and out_valid stays 1. There is no bubble.
- Inputs with in_valid=0 are never granted. Input data is sampled only on that channel's handshake edge.

Decomposition:
- Package hack_mux_pkg:
  - constants MODE_FIXED=1'b0 and MODE_RR=1'b1;
  - a function for the wrapped increment of a channel index.
- Sub-module hack_rr_arbiter:
  - parameter WAYS;
  - inputs: req[WAYS], ptr;
  - outputs: grant index and grant_valid;
  - purely combinational rotating-priority pick.
- The top level holds the output register, ptr and the mode mux.

Test Plan:
- Inputs use WAYS=8, WIDTH=16 with a=0x1234, b=0x2345, c=0x3456, d=0x4567, e=0x5678, f=0x6789, g=0x789A, h=0x89AB.
- Fixed mode, all in_valid=1, out_ready=1, sel stepped 0→7 one per cycle → on the cycle after each step out_data = 0x1234, 0x2345, …, 0x89AB, and out_chan equals the previous cycle's sel.
- Fixed mode, sel=3, in_valid[3]=0, others 1 → in_ready=0x00, out_valid drops to 0 after the current word drains, ptr stays 0.
- Round-robin, all valid, out_ready=1, from reset → out_chan sequence 0,1,…,7,0 on consecutive cycles with no bubbles, out_data matching each channel.
- Round-robin, in_valid=0b1000_0100, ptr=3 → grants go 7, then 2, then 7.
- Backpressure: load channel 5 (0x6789), hold out_ready=0 for 4 cycles → out_data stays 0x6789, out_valid stays 1, in_ready=0. Raising out_ready gives one transfer per cycle resuming with the next channel.
- Reset asserted while out_valid=1 and out_ready=0 → on the next edge out_valid=0, out_data=0, out_chan=0. The first grant after release goes to channel 0.
